// File: rtl/wb_regfile.sv
// Write-back stage register file: integer and float banks with write-through
// bypass on combinational read ports, and the selected write-back value exported.
module wb_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RegWrite_in,
    input  logic                  FloatRegWrite_in,
    input  logic [ADDR_WIDTH-1:0] Rd_in,
    input  logic                  MemtoReg_in,
    input  logic [DATA_WIDTH-1:0] data_after_HB_in,
    input  logic [DATA_WIDTH-1:0] alu_result_in,
    input  logic [ADDR_WIDTH-1:0] rs1_addr_in,
    input  logic [ADDR_WIDTH-1:0] rs2_addr_in,
    input  logic [ADDR_WIDTH-1:0] frs1_addr_in,
    input  logic [ADDR_WIDTH-1:0] frs2_addr_in,
    output logic [DATA_WIDTH-1:0] rs1_data_out,
    output logic [DATA_WIDTH-1:0] rs2_data_out,
    output logic [DATA_WIDTH-1:0] frs1_data_out,
    output logic [DATA_WIDTH-1:0] frs2_data_out,
    output logic [DATA_WIDTH-1:0] wb_data_out
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] int_reg   [NUM_REGS];
    logic [DATA_WIDTH-1:0] float_reg [NUM_REGS];
    logic [DATA_WIDTH-1:0] wb_data;
    logic                  int_we;

    assign wb_data     = MemtoReg_in ? data_after_HB_in : alu_result_in;
    assign wb_data_out = wb_data;

    // x0 is never written, so its storage stays at the reset value of zero.
    assign int_we = RegWrite_in && (Rd_in != '0);

    // No handshake: a write commits at every rising edge its enable is high.
    // Holding the same MEM/WB values during a stall simply rewrites the same data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                int_reg[i] <= '0;
            end
        end else if (int_we) begin
            int_reg[Rd_in] <= wb_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                float_reg[i] <= '0;
            end
        end else if (FloatRegWrite_in) begin
            float_reg[Rd_in] <= wb_data;
        end
    end

    // Integer reads: x0 wins over bypass, bypass wins over storage.
    assign rs1_data_out = (rs1_addr_in == '0)                      ? '0      :
                          (RegWrite_in && (Rd_in == rs1_addr_in)) ? wb_data :
                                                                     int_reg[rs1_addr_in];
    assign rs2_data_out = (rs2_addr_in == '0)                      ? '0      :
                          (RegWrite_in && (Rd_in == rs2_addr_in)) ? wb_data :
                                                                     int_reg[rs2_addr_in];

    assign frs1_data_out = (FloatRegWrite_in && (Rd_in == frs1_addr_in)) ? wb_data :
                                                                          float_reg[frs1_addr_in];
    assign frs2_data_out = (FloatRegWrite_in && (Rd_in == frs2_addr_in)) ? wb_data :
                                                                          float_reg[frs2_addr_in];

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: mux select, bypass, x0, bank isolation,
// dual-port reads, held inputs and asynchronous reset.
module tb_wb_regfile;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk;
    logic          rst;
    logic          reg_write;
    logic          float_reg_write;
    logic [AW-1:0] rd;
    logic          mem_to_reg;
    logic [DW-1:0] hb_data;
    logic [DW-1:0] alu_data;
    logic [AW-1:0] rs1_addr, rs2_addr, frs1_addr, frs2_addr;
    logic [DW-1:0] rs1_data, rs2_data, frs1_data, frs2_data, wb_data;

    int checks = 0;
    int errors = 0;

    wb_regfile #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk              (clk),
        .rst              (rst),
        .RegWrite_in      (reg_write),
        .FloatRegWrite_in (float_reg_write),
        .Rd_in            (rd),
        .MemtoReg_in      (mem_to_reg),
        .data_after_HB_in (hb_data),
        .alu_result_in    (alu_data),
        .rs1_addr_in      (rs1_addr),
        .rs2_addr_in      (rs2_addr),
        .frs1_addr_in     (frs1_addr),
        .frs2_addr_in     (frs2_addr),
        .rs1_data_out     (rs1_data),
        .rs2_data_out     (rs2_data),
        .frs1_data_out    (frs1_data),
        .frs2_data_out    (frs2_data),
        .wb_data_out      (wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rw, input logic fw, input logic [AW-1:0] dst,
                         input logic m2r, input logic [DW-1:0] hb, input logic [DW-1:0] alu);
        reg_write       = rw;
        float_reg_write = fw;
        rd              = dst;
        mem_to_reg      = m2r;
        hb_data         = hb;
        alu_data        = alu;
    endtask

    task automatic reads(input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                         input logic [AW-1:0] f1, input logic [AW-1:0] f2);
        rs1_addr  = a1;
        rs2_addr  = a2;
        frs1_addr = f1;
        frs2_addr = f2;
    endtask

    // Advance to 1 time unit past the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        reads(5'd5, 5'd10, 5'd3, 5'd7);
        #3;
        check("reset_rs1", rs1_data, 32'h0);
        check("reset_frs1", frs1_data, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // Mux select 0: ALU result, bypass then storage.
        reads(5'd1, 5'd10, 5'd1, 5'd1);
        drive(1'b1, 1'b0, 5'd10, 1'b0, 32'h1111_1111, 32'hDEAD_BEEF);
        #1;
        check("wb_alu", wb_data, 32'hDEAD_BEEF);
        check("rs2_bypass_alu", rs2_data, 32'hDEAD_BEEF);
        step();
        drive(1'b0, 1'b0, 5'd10, 1'b0, 32'h0, 32'h0);
        #1;
        check("rs2_stored_alu", rs2_data, 32'hDEAD_BEEF);

        // Mux select 1: load data.
        drive(1'b1, 1'b0, 5'd10, 1'b1, 32'h1111_1111, 32'hDEAD_BEEF);
        #1;
        check("wb_load", wb_data, 32'h1111_1111);
        check("rs2_bypass_load", rs2_data, 32'h1111_1111);
        step();
        idle();
        #1;
        check("rs2_stored_load", rs2_data, 32'h1111_1111);

        // x0 protection.
        reads(5'd0, 5'd0, 5'd0, 5'd0);
        drive(1'b1, 1'b0, 5'd0, 1'b0, 32'h0, 32'hFFFF_FFFF);
        #1;
        check("x0_rs1_same", rs1_data, 32'h0);
        check("x0_rs2_same", rs2_data, 32'h0);
        step();
        idle();
        #1;
        check("x0_rs1_after", rs1_data, 32'h0);
        check("x0_rs2_after", rs2_data, 32'h0);

        // f0 is an ordinary register.
        drive(1'b0, 1'b1, 5'd0, 1'b0, 32'h0, 32'hFFFF_FFFF);
        #1;
        check("f0_bypass", frs1_data, 32'hFFFF_FFFF);
        check("x0_during_fwrite", rs1_data, 32'h0);
        step();
        idle();
        #1;
        check("f0_stored", frs1_data, 32'hFFFF_FFFF);

        // Bank isolation: float write must not touch or bypass into int bank.
        reads(5'd3, 5'd3, 5'd3, 5'd3);
        drive(1'b0, 1'b1, 5'd3, 1'b0, 32'h0, 32'h3F80_0000);
        #1;
        check("f3_bypass", frs1_data, 32'h3F80_0000);
        check("x3_no_bypass", rs1_data, 32'h0);
        step();
        idle();
        #1;
        check("f3_stored", frs1_data, 32'h3F80_0000);
        check("x3_unchanged", rs1_data, 32'h0);

        // Both enables: same value into both banks.
        reads(5'd7, 5'd7, 5'd7, 5'd7);
        drive(1'b1, 1'b1, 5'd7, 1'b1, 32'hA5A5_A5A5, 32'h0);
        step();
        idle();
        #1;
        check("x7_both", rs1_data, 32'hA5A5_A5A5);
        check("f7_both", frs2_data, 32'hA5A5_A5A5);

        // Dual-port same address with concurrent write.
        reads(5'd12, 5'd12, 5'd12, 5'd12);
        drive(1'b1, 1'b0, 5'd12, 1'b0, 32'h0, 32'h0000_00C0);
        #1;
        check("dual_rs1", rs1_data, 32'h0000_00C0);
        check("dual_rs2", rs2_data, 32'h0000_00C0);
        check("dual_f12_no_bypass", frs1_data, 32'h0);
        step();
        idle();
        #1;
        check("dual_stored", rs2_data, 32'h0000_00C0);

        // Held (stalled) inputs.
        reads(5'd9, 5'd1, 5'd9, 5'd9);
        drive(1'b1, 1'b0, 5'd9, 1'b0, 32'h0, 32'h55);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stall_hold", rs1_data, 32'h55);
            step();
        end
        drive(1'b0, 1'b0, 5'd9, 1'b0, 32'h0, 32'h66);
        #1;
        check("stall_release", rs1_data, 32'h55);
        step();
        check("stall_after", rs1_data, 32'h55);

        // Reset clear: commit x5, then assert rst between edges.
        reads(5'd5, 5'd6, 5'd3, 5'd7);
        drive(1'b1, 1'b0, 5'd5, 1'b0, 32'h0, 32'h1234_5678);
        step();
        idle();
        #1;
        check("x5_committed", rs1_data, 32'h1234_5678);
        #1;
        rst = 1'b1;
        #1;
        check("x5_async_clear", rs1_data, 32'h0);
        check("f3_async_clear", frs1_data, 32'h0);
        check("f7_async_clear", frs2_data, 32'h0);

        // Write attempted under reset: bypass visible, nothing stored.
        drive(1'b1, 1'b0, 5'd6, 1'b0, 32'h0, 32'h77);
        #1;
        check("rst_bypass", rs2_data, 32'h77);
        step();
        idle();
        #1;
        check("rst_write_blocked", rs2_data, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step();
        step();
        check("x5_after_deassert", rs1_data, 32'h0);
        check("x6_after_deassert", rs2_data, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Integer and floating-point architectural register file that sits at the write-back end of the CPU pipeline and consumes the MEM/WB pipeline register outputs. Each cycle it picks the write-back value: load data when MemtoReg is set, otherwise the ALU result. It commits that value to the integer bank, the float bank, or both, and serves the ID stage's combinational read ports with write-through bypass. It also drives the selected write-back value out for EX-stage forwarding.

## Interface
Parameters:
- DATA_WIDTH, 32, register and data width
- ADDR_WIDTH, 5, register index width (2**ADDR_WIDTH entries per bank)

Ports:
- clk  input  1  clock; all register writes on rising edge
- rst  input  1  reset; asynchronous, active-high
- RegWrite_in  input  1  integer-bank write enable from MEM/WB
- FloatRegWrite_in  input  1  float-bank write enable from MEM/WB
- Rd_in  input  ADDR_WIDTH  destination index from MEM/WB
- MemtoReg_in  input  1  1 = write load data, 0 = write ALU result
- data_after_HB_in  input  DATA_WIDTH  load data after byte/half extension
- alu_result_in  input  DATA_WIDTH  ALU result
- rs1_addr_in, rs2_addr_in  input  ADDR_WIDTH  integer read indices from ID
- frs1_addr_in, frs2_addr_in  input  ADDR_WIDTH  float read indices from ID
- rs1_data_out, rs2_data_out  output  DATA_WIDTH  integer read data
- frs1_data_out, frs2_data_out  output  DATA_WIDTH  float read data
- wb_data_out  output  DATA_WIDTH  selected write-back value (for forwarding)

## Operation
- Storage: int_reg[0..31], float_reg[0..31], each DATA_WIDTH flops.
- wb_data_out = MemtoReg_in ? data_after_HB_in : alu_result_in. This path is combinational, with no width change.
- Integer write: on posedge clk, if RegWrite_in and Rd_in != 0, then int_reg[Rd_in] <= wb_data_out.
- x0 is hardwired: writes to index 0 are discarded, and int reads of index 0 return 0 with no bypass.
- Float write: on posedge clk, if FloatRegWrite_in, then float_reg[Rd_in] <= wb_data_out. f0 is an ordinary register.
- If RegWrite_in and FloatRegWrite_in are both 1, both banks are written with the same value. The decoder never does this, but the behaviour is deterministic.
- Read ports are combinational.
  - Int port: returns 0 if the address is 0. Otherwise, if RegWrite_in and Rd_in equals the address, it returns wb_data_out (bypass). Otherwise it returns int_reg[addr].
  - Float port: if FloatRegWrite_in and Rd_in equals the address, it returns wb_data_out. Otherwise it returns float_reg[addr].
- Bypass is independent per port. Both ports addressing the same register each get the bypassed value.
- There is no stall input. During CPU_stall the MEM/WB outputs are held, so the same value is rewritten every cycle. This rewrite is idempotent and required to be harmless.

## Timing
- Reset: rst high clears all 64 registers to 0 immediately, without waiting for a clock edge.
- While rst is high:
  - Read outputs return 0, except where a bypass applies.
  - Writes are blocked.
- First write is possible on the first rising edge after rst deasserts.
- Reset asserted mid-write: the register clears, and no partial write survives.
- Write latency: the value is architecturally visible through storage one cycle after the edge. It is visible the same cycle via bypass.
- Read latency: zero cycles (combinational). The read-to-output path is mux-only, with no dependency on clk.
- wb_data_out follows its inputs combinationally with zero latency.
- No handshake: the write is unconditional whenever an enable is high at the edge.

## Test plan
- Reset clear:
  - Write int_reg[5] = 0x1234_5678 and let it commit.
  - Assert rst between clock edges.
  - Required: rs1_data_out (addr 5) reads 0 immediately; after deassert it stays 0 with no writes.
- Write-then-read with mux select:
  - Cycle 0: RegWrite=1, Rd=10, MemtoReg=0, alu=0xDEAD_BEEF, data_after_HB=0x1111_1111.
  - Required: wb_data_out = 0xDEAD_BEEF; rs2 (addr 10) reads 0xDEAD_BEEF via bypass in cycle 0 and via storage in cycle 1.
  - Repeat with MemtoReg=1; required: 0x1111_1111.
- x0 protection:
  - RegWrite=1, Rd=0, alu=0xFFFF_FFFF.
  - Required: rs1/rs2 (addr 0) read 0 in the same cycle and after the edge.
  - Required: FloatRegWrite=1, Rd=0 stores 0xFFFF_FFFF in f0, and frs1 (addr 0) returns it.
- Bank isolation:
  - FloatRegWrite=1, Rd=3, value 0x3F80_0000.
  - Required: frs1 (addr 3) = 0x3F80_0000; rs1 (addr 3) is unchanged.
  - Both enables high with Rd=7, value 0xA5A5_A5A5; required: int_reg[7] and float_reg[7] both read 0xA5A5_A5A5.
- Dual-port same address: rs1 = rs2 = 12 with a concurrent write of 0x0000_00C0 to x12. Required: both ports return 0x0000_00C0 in the write cycle.
- Held (stalled) inputs: hold RegWrite=1, Rd=9, alu=0x55 for 5 cycles, then change alu to 0x66 with RegWrite=0. Required: x9 reads 0x55 throughout and after.
